// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues rd_en, absorbs the
// one-cycle read latency and re-presents words on a 2-entry valid/ready buffer.
module fifo_stream_reader #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              flush,
    input  logic              empty,
    input  logic [DWIDTH-1:0] out_data,
    output logic              rd_en,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready,
    output logic [CWIDTH-1:0] rd_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        occ_q, occ_d;
    logic              infl_q;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] tail_q, tail_d;
    logic [CWIDTH-1:0] cnt_q;

    logic       flush_entry;
    logic       push;
    logic       pop;
    logic [2:0] pend;

    assign flush_entry = flush && (state_q != S_FLUSH);
    assign m_valid     = (occ_q != 2'd0) && (state_q != S_FLUSH);
    assign m_data      = head_q;
    assign pop         = m_valid && m_ready;
    assign push        = infl_q && (state_q != S_FLUSH) && !flush_entry;
    assign rd_count    = cnt_q;
    assign busy        = (state_q != S_IDLE) || infl_q || (occ_q != 2'd0);

    // A delivery in this cycle frees a slot in time for the issued word.
    assign pend = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

    always_comb begin
        rd_en = 1'b0;
        unique case (state_q)
            S_RUN:   rd_en = !empty && (pend < 3'd2);
            S_FLUSH: rd_en = !empty;
            default: rd_en = 1'b0;
        endcase
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_entry) begin
            occ_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    occ_d = occ_q + 2'd1;
                    if (occ_q == 2'd0) head_d = out_data;
                    else               tail_d = out_data;
                end
                2'b01: begin
                    occ_d  = occ_q - 2'd1;
                    head_d = tail_q;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = out_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = out_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            infl_q <= rd_en && !empty;
            if (pop) cnt_q <= cnt_q + CWIDTH'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (flush)   state_q <= S_FLUSH;
                    else if (en) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (flush)    state_q <= S_FLUSH;
                    else if (!en) state_q <= S_IDLE;
                end
                S_FLUSH: begin
                    if (!flush && empty && !infl_q)
                        state_q <= en ? S_RUN : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and delivery scoreboard,
// directed scenarios followed by randomized en/ready/push traffic.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          flush;
    logic          empty;
    logic [DW-1:0] out_data;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] rd_count;
    logic          busy;

    fifo_stream_reader #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .flush    (flush),
        .empty    (empty),
        .out_data (out_data),
        .rd_en    (rd_en),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_count (rd_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            n_issued = 0;
    int            n_deliv = 0;
    int            cyc = 0;
    logic [CW-1:0] cnt_model = '0;
    bit            issue_prev = 1'b0;
    bit            stab_en = 1'b0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] hold_data;
    bit            s_rden;
    bit            s_valid;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        cyc++;
        s_rden     = rd_en;
        s_valid    = m_valid;
        issue_prev = rd_en && !empty;
        if (issue_prev) n_issued++;
        if (stab_en && hold_prev) begin
            check("stab_valid", 32'(m_valid), 32'd1);
            check("stab_data", 32'(m_data), 32'(hold_data));
        end
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("spurious", 32'd1, 32'd0);
            else check("data", 32'(m_data), 32'(exp_q.pop_front()));
            n_deliv++;
            cnt_model++;
        end
        if (stab_en)
            check("bound", 32'(n_issued - n_deliv <= 2), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (issue_prev) out_data = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        issue_prev = 1'b0;
        hold_prev  = 1'b0;
        empty      = 1'b1;
        cnt_model  = '0;
    endtask

    initial begin
        int d0, i0, first_rd, first_v, run, best, r;
        rstn = 1'b0; en = 1'b0; flush = 1'b0;
        m_ready = 1'b0; empty = 1'b1; out_data = '0;
        #12;
        check("rst_rden", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_cnt", 32'(rd_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rstn = 1'b1;
        tick();

        // Streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) push(DW'(i));
        en = 1'b1; m_ready = 1'b1;
        d0 = n_deliv; first_rd = -1; first_v = -1; run = 0; best = 0;
        for (int k = 0; k < 60 && (n_deliv - d0) < 16; k++) begin
            step();
            if (s_rden) begin
                run++;
                if (first_rd < 0) first_rd = cyc;
            end else run = 0;
            if (run > best) best = run;
            if (s_valid && first_v < 0) first_v = cyc;
        end
        check("stream_cnt", 32'(n_deliv - d0), 32'd16);
        check("stream_run", 32'(best), 32'd16);
        check("stream_lat", 32'(first_v - first_rd), 32'd2);
        sample();
        check("stream_rdcount", 32'(rd_count), 32'(cnt_model));
        tick();

        // Reset mid-stream
        for (int i = 0; i < 8; i++) push(DW'($urandom));
        for (int k = 0; k < 5; k++) step();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rden", 32'(rd_en), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_cnt", 32'(rd_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        clear_model();
        en = 1'b0; m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        sample();
        check("idle_rden", 32'(rd_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        sample();
        check("idle_rden2", 32'(rd_en), 32'd0);
        tick();

        // Backpressure with 5 words
        push(DW'($urandom)); push(DW'($urandom));
        en = 1'b1; m_ready = 1'b0;
        i0 = n_issued;
        for (int k = 0; k < 8; k++) step();
        check("bp_reads", 32'(n_issued - i0), 32'd2);
        sample();
        check("bp_rden", 32'(rd_en), 32'd0);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", 32'(m_data), 32'(exp_q[0]));
        check("bp_fifo", 32'(fifo_q.size()), 32'd3);
        tick();
        m_ready = 1'b1;
        d0 = n_deliv;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
        check("bp_deliv", 32'(n_deliv - d0), 32'd5);

        // Flush with 2 buffered, 3 in the FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'($urandom));
        for (int k = 0; k < 8; k++) step();
        flush = 1'b1;
        sample();
        check("fl_entry_valid", 32'(m_valid), 32'd1);
        tick();
        exp_q.delete();
        sample();
        check("fl_valid", 32'(m_valid), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) step();
        sample();
        check("fl_drain", 32'(fifo_q.size()), 32'd0);
        check("fl_cnt", 32'(rd_count), 32'(cnt_model));
        check("fl_busy", 32'(busy), 32'd1);
        tick();
        flush = 1'b0;
        step();
        push(8'hA5);
        sample();
        check("fl_run", 32'(rd_en), 32'd1);
        tick();
        m_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
        check("fl_post", 32'(exp_q.size()), 32'd0);

        // Disable right after a read issue
        en = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        en = 1'b1;
        step();
        i0 = n_issued; d0 = n_deliv;
        step();
        en = 1'b0;
        step();
        r = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_rden) r++;
        end
        check("dis_rden_after", 32'(r), 32'd0);
        check("dis_some", 32'(n_issued - i0 >= 1), 32'd1);
        check("dis_deliv", 32'(n_deliv - d0), 32'(n_issued - i0));
        sample();
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_fifo", 32'(fifo_q.size()), 32'(4 - (n_issued - i0)));
        tick();

        // Randomized traffic
        n_issued = 0; n_deliv = 0; hold_prev = 1'b0; stab_en = 1'b1;
        for (int k = 0; k < 800; k++) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 12)
                push(DW'($urandom));
            step();
        end
        en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) step();
        stab_en = 1'b0;
        check("rnd_drain", 32'(exp_q.size()), 32'd0);
        sample();
        check("rnd_cnt", 32'(rd_count), 32'(cnt_model));
        tick();

        // Counter wrap: 17 words on a 4-bit counter
        rstn = 1'b0;
        clear_model();
        en = 1'b0;
        @(negedge clk); rstn = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) push(DW'($urandom));
        en = 1'b1; m_ready = 1'b1;
        d0 = n_deliv;
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) step();
        check("wrap_deliv", 32'(n_deliv - d0), 32'd17);
        sample();
        check("wrap_cnt", 32'(rd_count), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
